// File: rtl/phy_rx_packer.sv
// rtl/phy_rx_packer.sv - PIPE receive packer: framing detect, lane de-stripe, beat packing (Gen3+ tokens under PHY_RX_PACKER_GEN3_EN)
package phy_rx_packer_pkg;
  typedef enum logic [2:0] {GEN1 = 3'd0, GEN2, GEN3, GEN4, GEN5} rate_speed_e;
endpackage

module phy_rx_packer
  import phy_rx_packer_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_NUM_LANES = 4,
  parameter int OUT_BYTES     = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              phy_link_up_i,
  input  rate_speed_e                       curr_data_rate_i,
  input  logic [5:0]                        pipe_width_i,
  input  logic [5:0]                        num_active_lanes_i,
  input  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data_i,
  input  logic [4*MAX_NUM_LANES-1:0]        data_k_i,
  input  logic [MAX_NUM_LANES-1:0]          data_valid_i,
  output logic [8*OUT_BYTES-1:0]            out_data_o,
  output logic [OUT_BYTES-1:0]              out_keep_o,
  output logic [OUT_BYTES-1:0]              out_k_o,
  output logic                              out_sop_o,
  output logic                              out_eop_o,
  output logic                              out_abort_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic                              overflow_o,
  output logic                              cfg_err_o
);
  localparam int IN_BYTES = MAX_NUM_LANES * DATA_WIDTH / 8;
  localparam int OFF_W    = $clog2(OUT_BYTES) + 1;
  localparam logic [OFF_W-1:0] OUT_FULL = OFF_W'(OUT_BYTES);
  localparam logic [7:0] K_STP = 8'hFB, K_SDP = 8'h5C, K_END = 8'hFD, K_EDB = 8'hFE;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISCARD} state_e;
  state_e state_q, state_d;

  rate_speed_e rate_q, rate_e;
  logic [5:0] width_q, lanes_q, width_e, lanes_e;
  logic [2:0] lane_sh;
  logic [OFF_W-1:0] nb, take, fill, off_q, off_d;
  logic [MAX_NUM_LANES-1:0] lane_mask;
  logic is_8b10b, width_ok, lanes_ok, cfg_ok, accept;
  logic [8*IN_BYTES-1:0] ing_byte;
  logic [IN_BYTES-1:0] ing_k;
  logic start_hit, pkt_end, end_abort;
  logic wr, emit, emit_eop, emit_abort, emit_sop, load, drop, sop_pend_q, sop_pend_d;
  logic [8*OUT_BYTES-1:0] asm_q, asm_d;
  logic [OUT_BYTES-1:0] asmk_q, asmk_d, keep_d;
  int ln, sy, idx;
`ifdef PHY_RX_PACKER_GEN3_EN
  logic [12:0] rem_q, rem_d, tot;
  logic [10:0] stp_len;
  logic short_q, short_d;
`endif

  // Rate/width/lanes follow the inputs in IDLE and are frozen for the rest of a packet
  assign rate_e  = (state_q == S_IDLE) ? curr_data_rate_i   : rate_q;
  assign width_e = (state_q == S_IDLE) ? pipe_width_i       : width_q;
  assign lanes_e = (state_q == S_IDLE) ? num_active_lanes_i : lanes_q;

  // Configuration decode: legality, beat size, lane shift and ingress accept
  always_comb begin
    is_8b10b = (rate_e == GEN1) || (rate_e == GEN2);
    width_ok = (width_e == 6'd8) || (width_e == 6'd16 && DATA_WIDTH >= 16) ||
               (width_e == 6'd32 && DATA_WIDTH >= 32);
    lanes_ok = (lanes_e == 6'd1 || lanes_e == 6'd2 || lanes_e == 6'd4 ||
                lanes_e == 6'd8 || lanes_e == 6'd16) && (lanes_e <= 6'(MAX_NUM_LANES));
    case (lanes_e)
      6'd2:    lane_sh = 3'd1;
      6'd4:    lane_sh = 3'd2;
      6'd8:    lane_sh = 3'd3;
      6'd16:   lane_sh = 3'd4;
      default: lane_sh = 3'd0;
    endcase
    nb = OFF_W'(width_e[5:3]) << lane_sh;
    for (int l = 0; l < MAX_NUM_LANES; l++) lane_mask[l] = (l < int'(lanes_e));
`ifdef PHY_RX_PACKER_GEN3_EN
    cfg_ok = width_ok && lanes_ok;
`else
    cfg_ok = width_ok && lanes_ok && is_8b10b;
`endif
    accept = phy_link_up_i && cfg_ok && ((data_valid_i & lane_mask) == lane_mask);
  end

  // De-stripe: ingress byte k comes from lane k mod N, symbol k div N
  always_comb begin
    ing_byte = '0;
    ing_k    = '0;
    ln = 0;
    sy = 0;
    for (int k = 0; k < IN_BYTES; k++) begin
      ln = k & (int'(lanes_e) - 1);
      sy = k >> lane_sh;
      if (ln < MAX_NUM_LANES && sy < DATA_WIDTH / 8) begin
        ing_byte[8*k +: 8] = data_i[ln*DATA_WIDTH + 8*sy +: 8];
        ing_k[k +: 1]      = data_k_i[4*ln + sy +: 1];
      end
    end
  end

  // Framing: packet start, bytes taken from this beat, and packet end
  always_comb begin
    start_hit = 1'b0;
    take      = nb;
    pkt_end   = 1'b0;
    end_abort = 1'b0;
`ifdef PHY_RX_PACKER_GEN3_EN
    rem_d   = rem_q;
    short_d = short_q;
    tot     = '0;
    stp_len = {ing_byte[14:8], ing_byte[7:4]};
`endif
    if (is_8b10b) begin
      if (state_q == S_IDLE)
        start_hit = ing_k[0] && (ing_byte[7:0] == K_STP || ing_byte[7:0] == K_SDP);
      // Scan downwards so the lowest END/EDB in the beat wins
      for (int k = IN_BYTES - 1; k >= 0; k--) begin
        if (k < int'(nb) && ing_k[k] && (ing_byte[8*k +: 8] == K_END || ing_byte[8*k +: 8] == K_EDB)) begin
          pkt_end   = 1'b1;
          take      = OFF_W'(k + 1);
          end_abort = (ing_byte[8*k +: 8] == K_EDB);
        end
      end
    end
`ifdef PHY_RX_PACKER_GEN3_EN
    else begin
      // STP Length counts whole DWs including the token; a too-short Length keeps only the token
      if (state_q == S_IDLE) begin
        if (ing_byte[3:0] == 4'hF) begin
          start_hit = 1'b1;
          short_d   = (stp_len < 11'd5);
          tot       = short_d ? 13'd4 : {stp_len, 2'b00};
        end else if (ing_byte[7:0] == 8'hF0 && ing_byte[15:8] == 8'hAC) begin
          start_hit = 1'b1;
          short_d   = 1'b0;
          tot       = 13'd8;
        end
      end else begin
        tot = rem_q;
      end
      if (tot <= 13'(nb)) begin
        pkt_end = 1'b1;
        take    = OFF_W'(tot);
        rem_d   = '0;
      end else begin
        rem_d = tot - 13'(nb);
      end
      end_abort = short_d;
    end
`endif
  end

  // Packet FSM next state: assembly offset, beat emit and overflow drop
  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    sop_pend_d = sop_pend_q;
    wr         = 1'b0;
    emit       = 1'b0;
    emit_eop   = 1'b0;
    emit_abort = 1'b0;
    fill       = off_q;
    emit_sop   = sop_pend_q || (state_q == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (accept && start_hit) begin
          wr         = 1'b1;
          fill       = take;
          sop_pend_d = 1'b1;
          emit       = pkt_end || (take == OUT_FULL);
          emit_eop   = pkt_end;
          emit_abort = pkt_end && end_abort;
          state_d    = pkt_end ? S_IDLE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (!phy_link_up_i) begin
          emit       = 1'b1;
          emit_eop   = 1'b1;
          emit_abort = 1'b1;
          state_d    = S_IDLE;
        end else if (accept) begin
          wr         = 1'b1;
          fill       = off_q + take;
          emit       = pkt_end || (fill == OUT_FULL);
          emit_eop   = pkt_end;
          emit_abort = pkt_end && end_abort;
          if (pkt_end) state_d = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (!phy_link_up_i || (accept && pkt_end)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (wr) off_d = fill;
    if (emit) begin
      off_d      = '0;
      sop_pend_d = 1'b0;
    end
    load = emit && (!out_valid_o || out_ready_i);
    drop = emit && !load;
    if (drop && state_d == S_COLLECT) state_d = S_DISCARD;
    for (int j = 0; j < OUT_BYTES; j++) keep_d[j] = (j < int'(fill));
  end

  // Merge the taken bytes of this beat into the assembly at the current offset
  always_comb begin
    asm_d  = asm_q;
    asmk_d = asmk_q;
    idx    = 0;
    for (int j = 0; j < OUT_BYTES; j++) begin
      idx = j - int'(off_q);
      if (wr && idx >= 0 && idx < int'(take) && idx < IN_BYTES) begin
        asm_d[8*j +: 8] = ing_byte[8*idx +: 8];
        asmk_d[j +: 1]  = ing_k[idx +: 1];
      end
    end
  end

  // State, offset, frozen configuration and status pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      off_q      <= '0;
      sop_pend_q <= 1'b0;
      rate_q     <= GEN1;
      width_q    <= 6'd8;
      lanes_q    <= 6'd1;
      overflow_o <= 1'b0;
      cfg_err_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      sop_pend_q <= sop_pend_d;
      if (state_q == S_IDLE) begin
        rate_q  <= curr_data_rate_i;
        width_q <= pipe_width_i;
        lanes_q <= num_active_lanes_i;
      end
      overflow_o <= drop;
      cfg_err_o  <= !cfg_ok;
    end
  end

`ifdef PHY_RX_PACKER_GEN3_EN
  // Gen3+ remaining-byte counter and short-STP abort flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q   <= '0;
      short_q <= 1'b0;
    end else if (accept) begin
      rem_q   <= rem_d;
      short_q <= short_d;
    end
  end
`endif

  // Assembly buffer contents are qualified by the offset, so they need no reset
  always_ff @(posedge clk_i) begin
    asm_q  <= asm_d;
    asmk_q <= asmk_d;
  end

  // Holding register control: load on emit when free or being consumed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_keep_o  <= '0;
      out_sop_o   <= 1'b0;
      out_eop_o   <= 1'b0;
      out_abort_o <= 1'b0;
    end else if (load) begin
      out_valid_o <= 1'b1;
      out_keep_o  <= keep_d;
      out_sop_o   <= emit_sop;
      out_eop_o   <= emit_eop;
      out_abort_o <= emit_abort;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  // Holding register payload
  always_ff @(posedge clk_i) begin
    if (load) begin
      out_data_o <= asm_d;
      out_k_o    <= asmk_d;
    end
  end
endmodule

// File: tb/tb_phy_rx_packer.sv
// tb/tb_phy_rx_packer.sv - self-checking bench for phy_rx_packer
module tb_phy_rx_packer;
  import phy_rx_packer_pkg::*;

  logic clk = 1'b0;
  logic rst_n, link, ready;
  rate_speed_e rate;
  logic [5:0] width, lanes;
  logic [255:0] data;
  logic [31:0] data_k;
  logic [7:0] dvalid;
  logic [511:0] out_data;
  logic [63:0] keep, outk;
  logic sop, eop, abrt, valid, ovf, cfg_err;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic [63:0]  k;
    logic         sop, eop, abort;
  } beat_t;

  beat_t exp_q[$];
  logic [7:0] pkt_b[$];
  logic pkt_k[$];
  int total = 0, bad = 0, ovf_seen = 0, ovf_exp = 0;

  phy_rx_packer #(.DATA_WIDTH(32), .MAX_NUM_LANES(8), .OUT_BYTES(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .phy_link_up_i(link), .curr_data_rate_i(rate),
    .pipe_width_i(width), .num_active_lanes_i(lanes), .data_i(data), .data_k_i(data_k),
    .data_valid_i(dvalid), .out_data_o(out_data), .out_keep_o(keep), .out_k_o(outk),
    .out_sop_o(sop), .out_eop_o(eop), .out_abort_o(abrt), .out_valid_o(valid),
    .out_ready_i(ready), .overflow_o(ovf), .cfg_err_o(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mk_pkt(input int n, input logic [7:0] b0, input logic k0, input logic [7:0] bl, input logic kl);
    pkt_b.delete();
    pkt_k.delete();
    for (int i = 0; i < n; i++) begin
      pkt_b.push_back(8'(i * 29 + 7));
      pkt_k.push_back(1'b0);
    end
    pkt_b[0] = b0; pkt_k[0] = k0;
    pkt_b[n-1] = bl; pkt_k[n-1] = kl;
  endtask

  // Expected beats: the first upto packet bytes cut into 64-byte chunks
  task automatic expect_pkt(input int upto, input bit eop_on, input bit ab);
    beat_t b;
    int s = 0;
    while (s < upto) begin
      b.data = '0; b.keep = '0; b.k = '0;
      for (int j = 0; j < 64 && s + j < upto; j++) begin
        b.data[8*j +: 8] = pkt_b[s+j];
        b.keep[j] = 1'b1;
        b.k[j] = pkt_k[s+j];
      end
      b.sop = (s == 0);
      s += 64;
      b.eop = eop_on && (s >= upto);
      b.abort = ab && b.eop;
      exp_q.push_back(b);
    end
  endtask

  // Stripe the first n packet bytes over the active lanes, one ingress beat per clock
  task automatic send(input int n);
    int bb, ln, sy;
    bb = (int'(width) / 8) * int'(lanes);
    for (int s = 0; s < n; s += bb) begin
      data = '0; data_k = '0;
      for (int i = 0; i < bb; i++) begin
        ln = i % int'(lanes);
        sy = i / int'(lanes);
        if (s + i < n) begin
          data[ln*32 + sy*8 +: 8] = pkt_b[s+i];
          data_k[ln*4 + sy] = pkt_k[s+i];
        end
      end
      dvalid = '1;
      @(posedge clk); #1;
    end
    dvalid = '0; data = '0; data_k = '0;
  endtask

  task automatic idle(input int n);
    dvalid = '0; data = '0; data_k = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Compare process: accepted beats against the model, holding stability, overflow pulses
  bit hold_chk = 0;
  logic [511:0] p_data;
  logic [63:0] p_keep, p_k;
  logic [2:0] p_flags;
  always @(negedge clk) begin
    beat_t e;
    logic [511:0] m;
    if (!rst_n) hold_chk = 0;
    else begin
      if (ovf) ovf_seen++;
      if (hold_chk) begin
        chk("hold_valid", valid, 1'b1);
        chk("hold_data", out_data, p_data);
        chk("hold_keep", keep, p_keep);
        chk("hold_k", outk, p_k);
        chk("hold_flags", {sop, eop, abrt}, p_flags);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got keep %0h, no beat expected", keep);
        end else begin
          e = exp_q.pop_front();
          m = '0;
          for (int j = 0; j < 64; j++) if (e.keep[j]) m[8*j +: 8] = 8'hFF;
          chk("beat_keep", keep, e.keep);
          chk("beat_sop", sop, e.sop);
          chk("beat_eop", eop, e.eop);
          chk("beat_abort", abrt, e.abort);
          chk("beat_data", out_data & m, e.data & m);
          chk("beat_k", outk & e.keep, e.k & e.keep);
        end
      end
      hold_chk = valid && !ready;
      p_data = out_data; p_keep = keep; p_k = outk; p_flags = {sop, eop, abrt};
    end
  end

  initial begin
    rst_n = 0; link = 1; ready = 1; rate = GEN1; width = 6'd8; lanes = 6'd4;
    data = '0; data_k = '0; dvalid = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_keep", keep, 64'h0);
    chk("rst_flags", {sop, eop, abrt}, 3'b000);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    rst_n = 1;
    idle(2);

    // Gen1 x4 8-bit, 24-byte STP..END packet
    mk_pkt(24, 8'hFB, 1'b1, 8'hFD, 1'b1);
    expect_pkt(24, 1, 0);
    send(24);
    chk("g1_valid", valid, 1'b1);
    chk("g1_keep", keep, 64'h0000_0000_00FF_FFFF);
    chk("g1_sop_eop", {sop, eop, abrt}, 3'b110);
    idle(3);

    // Gen2 x4 16-bit, 140-byte SDP..EDB packet
    rate = GEN2; width = 6'd16;
    mk_pkt(140, 8'h5C, 1'b1, 8'hFE, 1'b1);
    expect_pkt(140, 1, 1);
    send(140);
    chk("g2_keep3", keep, 64'hFFF);
    chk("g2_eop_abort", {sop, eop, abrt}, 3'b011);
    idle(3);

    // Gen3 x8 32-bit: STP Length=6 then SDP in the next beat
    rate = GEN3; width = 6'd32; lanes = 6'd8;
`ifdef PHY_RX_PACKER_GEN3_EN
    mk_pkt(24, 8'h6F, 1'b0, 8'h11, 1'b0);
    pkt_b[1] = 8'h00;
    expect_pkt(24, 1, 0);
    send(24);
    chk("g3_stp_keep", keep, 64'hFF_FFFF);
    mk_pkt(8, 8'hF0, 1'b0, 8'h22, 1'b0);
    pkt_b[1] = 8'hAC;
    expect_pkt(8, 1, 0);
    send(8);
    chk("g3_sdp_keep", keep, 64'hFF);
    chk("g3_sdp_flags", {sop, eop, abrt}, 3'b110);
`else
    idle(1);
    chk("g3_cfg_err", cfg_err, 1'b1);
    mk_pkt(24, 8'h6F, 1'b0, 8'h11, 1'b0);
    send(24);
    chk("g3_no_beat", valid, 1'b0);
`endif
    idle(3);
    rate = GEN2; width = 6'd16; lanes = 6'd4;
    idle(1);
    chk("cfg_err_clear", cfg_err, 1'b0);

    // Backpressure: second 64-byte beat is dropped, rest of packet discarded
    ready = 0;
    mk_pkt(160, 8'hFB, 1'b1, 8'hFD, 1'b1);
    expect_pkt(64, 0, 0);
    ovf_exp++;
    send(160);
    idle(3);
    chk("bp_valid_held", valid, 1'b1);
    chk("bp_sop", {sop, eop}, 2'b10);
    ready = 1;
    idle(2);
    mk_pkt(16, 8'h5C, 1'b1, 8'hFD, 1'b1);
    expect_pkt(16, 1, 0);
    send(16);
    idle(3);

    // Link down after 20 of 100 bytes
    rate = GEN1; width = 6'd8; lanes = 6'd4;
    mk_pkt(100, 8'hFB, 1'b1, 8'hFD, 1'b1);
    expect_pkt(20, 1, 1);
    send(20);
    link = 0;
    @(posedge clk); #1;
    chk("ld_valid", valid, 1'b1);
    chk("ld_keep", keep, 64'hF_FFFF);
    chk("ld_flags", {sop, eop, abrt}, 3'b111);
    link = 1;
    idle(2);
    mk_pkt(8, 8'hFB, 1'b1, 8'hFD, 1'b1);
    expect_pkt(8, 1, 0);
    send(8);
    idle(3);

    // Unsupported lane count
    lanes = 6'd3;
    idle(1);
    chk("cfg3_err", cfg_err, 1'b1);
    data = '0; data[7:0] = 8'hFB; data_k = '0; data_k[0] = 1'b1; dvalid = '1;
    repeat (3) begin @(posedge clk); #1; end
    chk("cfg3_no_beat", valid, 1'b0);
    lanes = 6'd4;
    idle(2);
    chk("cfg4_ok", cfg_err, 1'b0);

    // Asynchronous reset mid-packet with a beat held
    ready = 0;
    mk_pkt(24, 8'hFB, 1'b1, 8'hFD, 1'b1);
    send(24);
    mk_pkt(40, 8'hFB, 1'b1, 8'hFD, 1'b1);
    send(12);
    chk("pre_rst_valid", valid, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", valid, 1'b0);
    chk("arst_keep", keep, 64'h0);
    chk("arst_flags", {sop, eop, abrt, ovf, cfg_err}, 5'b0);
    @(posedge clk); #1;
    rst_n = 1;
    ready = 1;
    idle(3);
    mk_pkt(24, 8'h5C, 1'b1, 8'hFD, 1'b1);
    expect_pkt(24, 1, 0);
    send(24);
    idle(5);

    chk("ovf_count", ovf_seen, ovf_exp);
    chk("exp_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
